sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO; next generation of the team's FIFO DUT. Adds configurable width/depth,

---
 rtl/shared_pkg.sv | 13 +
 rtl/fifo_sat_counter.sv | 20 ++
 rtl/sync_fifo_param.sv | 105 ++++++++++
 tb/tb_sync_fifo_param.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/shared_pkg.sv
// Shared FIFO types and defaults used by the FIFO RTL and its bench.
package shared_pkg;

   typedef enum logic [1:0] {
      EV_NONE,
      EV_OVF,
      EV_UDF
   } fifo_event_e;

   localparam int FIFO_DATA_WIDTH = 16;
   localparam int FIFO_DEPTH      = 8;

endpackage

// File: rtl/fifo_sat_counter.sv
// Saturating event counter: counts inc pulses, holds at all-ones, clr wins over inc.
module fifo_sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] value
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         value <= '0;
      end else if (inc && (value != '1)) begin
         value <= value + 1'b1;
      end
   end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable almost flags and
// saturating overflow/underflow event counters.
module sync_fifo_param
   import shared_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int DEPTH      = FIFO_DEPTH,
   parameter int AF_LEVEL   = DEPTH - 1,
   parameter int AE_LEVEL   = 1,
   parameter int CNT_W      = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_WIDTH-1:0]      data_in,
   input  logic                       wr_en,
   input  logic                       rd_en,
   input  logic                       cnt_clr,
   output logic [DATA_WIDTH-1:0]      data_out,
   output logic                       wr_ack,
   output logic                       overflow,
   output logic                       underflow,
   output logic                       full,
   output logic                       empty,
   output logic                       almostfull,
   output logic                       almostempty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [CNT_W-1:0]           ovf_count,
   output logic [CNT_W-1:0]           udf_count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic                  wr_ok;
   logic                  rd_ok;

   // Handshake: a write is taken when wr_en is high and the FIFO is not full,
   // or is full but a read is taken in the same cycle; a read is taken when
   // rd_en is high and the FIFO is not empty. No write-through on empty.
   assign rd_ok = rd_en && !empty;
   assign wr_ok = wr_en && (!full || rd_en);

   assign full        = (count == CW'(DEPTH));
   assign empty       = (count == '0);
   assign almostfull  = (count >= CW'(AF_LEVEL)) && !full;
   assign almostempty = !empty && (count <= CW'(AE_LEVEL));

   always_ff @(posedge clk) begin
      if (!rst && wr_ok) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         data_out  <= '0;
         wr_ack    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         wr_ack    <= wr_ok;
         overflow  <= wr_en && !wr_ok;
         underflow <= rd_en && !rd_ok;
         if (wr_ok) begin
            wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   fifo_sat_counter #(.CNT_W(CNT_W)) u_ovf_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (wr_en && !wr_ok),
      .clr   (cnt_clr),
      .value (ovf_count)
   );

   fifo_sat_counter #(.CNT_W(CNT_W)) u_udf_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (rd_en && !rd_ok),
      .clr   (cnt_clr),
      .value (udf_count)
   );

   a_count_range : assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));
   a_full_empty  : assert property (@(posedge clk) disable iff (rst) !(full && empty));
   a_ack_ovf     : assert property (@(posedge clk) disable iff (rst) !(wr_ack && overflow));

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: driver pushes expected results, monitor compares.
module tb_sync_fifo_param;

   localparam int W = 16;
   localparam int D = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  data_in = '0;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic          cnt_clr = 1'b0;
   logic [W-1:0]  data_out;
   logic          wr_ack, overflow, underflow;
   logic          full, empty, almostfull, almostempty;
   logic [3:0]    count;
   logic [7:0]    ovf_count, udf_count;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic       rst;
      logic       rd_ok;
      logic       ack;
      logic       ovf;
      logic       udf;
      logic [3:0] cnt;
      logic [7:0] oc;
      logic [7:0] uc;
   } rec_t;

   rec_t         st_q[$];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mq[$];
   logic [7:0]   m_oc = '0;
   logic [7:0]   m_uc = '0;

   sync_fifo_param #(
      .DATA_WIDTH(W), .DEPTH(D), .AF_LEVEL(7), .AE_LEVEL(1), .CNT_W(8)
   ) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
      .cnt_clr(cnt_clr), .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow),
      .underflow(underflow), .full(full), .empty(empty), .almostfull(almostfull),
      .almostempty(almostempty), .count(count), .ovf_count(ovf_count),
      .udf_count(udf_count)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // driver: apply one cycle of inputs and push the expected outcome
   task automatic cyc(input logic r, input logic w, input logic rd, input logic c,
                      input logic [W-1:0] d);
      rec_t e;
      logic full_m, empty_m, rok, wok;
      @(negedge clk);
      rst = r; wr_en = w; rd_en = rd; cnt_clr = c; data_in = d;
      e = '0;
      if (r) begin
         mq.delete();
         m_oc = '0;
         m_uc = '0;
         e.rst = 1'b1;
      end else begin
         full_m  = (mq.size() == D);
         empty_m = (mq.size() == 0);
         rok = rd && !empty_m;
         wok = w && (!full_m || rd);
         if (rok) exp_q.push_back(mq.pop_front());
         if (wok) mq.push_back(d);
         if (c) begin
            m_oc = '0;
            m_uc = '0;
         end else begin
            if (w && !wok && m_oc != 8'hFF) m_oc = m_oc + 8'd1;
            if (rd && !rok && m_uc != 8'hFF) m_uc = m_uc + 8'd1;
         end
         e.rd_ok = rok;
         e.ack   = wok;
         e.ovf   = w && !wok;
         e.udf   = rd && !rok;
      end
      e.cnt = 4'(mq.size());
      e.oc  = m_oc;
      e.uc  = m_uc;
      st_q.push_back(e);
   endtask

   // directed check right after the edge that applied the last cyc
   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   // monitor / scoreboard
   rec_t         r_m;
   logic [W-1:0] last_dout = '0;
   always @(posedge clk) begin
      #1;
      if (st_q.size() > 0) begin
         r_m = st_q.pop_front();
         if (r_m.rst) begin
            last_dout = '0;
         end else if (r_m.rd_ok) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL exp_q_underrun at %0t", $time);
            end else begin
               last_dout = exp_q.pop_front();
            end
         end
         chk("data_out",    32'(data_out),    32'(last_dout));
         chk("wr_ack",      32'(wr_ack),      32'(r_m.ack));
         chk("overflow",    32'(overflow),    32'(r_m.ovf));
         chk("underflow",   32'(underflow),   32'(r_m.udf));
         chk("count",       32'(count),       32'(r_m.cnt));
         chk("full",        32'(full),        32'(r_m.cnt == 4'd8));
         chk("empty",       32'(empty),       32'(r_m.cnt == 4'd0));
         chk("almostfull",  32'(almostfull),  32'(r_m.cnt == 4'd7));
         chk("almostempty", 32'(almostempty), 32'(r_m.cnt == 4'd1));
         chk("ovf_count",   32'(ovf_count),   32'(r_m.oc));
         chk("udf_count",   32'(udf_count),   32'(r_m.uc));
      end
   end

   initial begin
      int wait_cnt;
      // reset then idle
      cyc(1, 0, 0, 0, '0);
      cyc(1, 0, 0, 0, '0);
      cyc(0, 0, 0, 0, '0);
      after_edge();
      chk("idle_empty", 32'(empty), 32'd1);

      // fill 0x0001..0x0008, then overflow with 0xDEAD
      for (int i = 1; i <= 8; i++) cyc(0, 1, 0, 0, W'(i));
      after_edge();
      chk("fill_full", 32'(full), 32'd1);
      cyc(0, 1, 0, 0, 16'hDEAD);
      after_edge();
      chk("ovf_once", 32'(ovf_count), 32'd1);

      // drain 8, then one rejected read
      for (int i = 1; i <= 9; i++) cyc(0, 0, 1, 0, '0);
      after_edge();
      chk("udf_hold_data", 32'(data_out), 32'h0008);
      chk("udf_once", 32'(udf_count), 32'd1);

      // full with simultaneous write/read
      for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 16'h0011 + W'(i));
      cyc(0, 1, 1, 0, 16'h00AA);
      after_edge();
      chk("full_wr_rd_data", 32'(data_out), 32'h0011);
      chk("full_wr_rd_ovf", 32'(overflow), 32'd0);
      chk("full_wr_rd_cnt", 32'(count), 32'd8);
      for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, '0);
      after_edge();
      chk("drain_last_aa", 32'(data_out), 32'h00AA);

      // empty with simultaneous write/read
      cyc(0, 1, 1, 0, 16'h0055);
      after_edge();
      chk("empty_wr_rd_udf", 32'(underflow), 32'd1);
      chk("empty_wr_rd_cnt", 32'(count), 32'd1);
      cyc(0, 0, 1, 0, '0);
      after_edge();
      chk("read_55", 32'(data_out), 32'h0055);

      // saturate underflow counter, then clear coincident with a rejection
      for (int i = 0; i < 300; i++) cyc(0, 0, 1, 0, '0);
      after_edge();
      chk("udf_sat", 32'(udf_count), 32'd255);
      cyc(0, 0, 1, 1, '0);
      after_edge();
      chk("clr_wins", 32'(udf_count), 32'd0);

      // reset mid-burst with count=5; write during reset is ignored
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 16'h0100 + W'(i));
      cyc(1, 1, 0, 0, 16'h0777);
      after_edge();
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_count", 32'(count), 32'd0);
      cyc(0, 0, 1, 0, '0);
      cyc(0, 0, 0, 0, '0);

      wait_cnt = 0;
      while (st_q.size() != 0 && wait_cnt < 20) begin
         @(posedge clk);
         wait_cnt++;
      end
      #3;
      chk("drain_timeout", 32'(st_q.size()), 32'd0);
      chk("exp_q_left", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
